// File: rtl/dmem_write_buffer.sv
// MEM-stage data memory: word array fronted by a 2-entry posted write buffer.
// Loads bypass from the buffer; the buffer drains only when no load is pending.
module dmem_write_buffer #(
    parameter int ADDR_W = 8
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        MemRd_i,
    input  logic        MemWr_i,
    input  logic [15:0] Addr_i,
    input  logic [15:0] DataIn_i,
    output logic [15:0] DataOut_o,
    output logic        busy_o,
    output logic [1:0]  wb_count_o
);

    logic [15:0]       mem_q [2**ADDR_W];
    logic [ADDR_W-1:0] addr_q [2];
    logic [ADDR_W-1:0] addr_d [2];
    logic [15:0]       data_q [2];
    logic [15:0]       data_d [2];
    logic [1:0]        count_q;
    logic [1:0]        count_d;

    logic [ADDR_W-1:0] idx;
    logic              is_st;
    logic              is_ld;
    logic              hit0;
    logic              hit1;
    logic              match;
    logic              drain;
    logic              alloc;
    logic [15:0]       data_c0;
    logic [15:0]       data_c1;
    logic [1:0]        cnt_tmp;
    logic              unused_addr;

    assign unused_addr = ^Addr_i[15:ADDR_W];

    always_comb begin
        idx     = Addr_i[ADDR_W-1:0];
        is_st   = MemWr_i;
        is_ld   = MemRd_i & ~MemWr_i;
        hit0    = (count_q != 2'd0) && (addr_q[0] == idx);
        hit1    = (count_q == 2'd2) && (addr_q[1] == idx);
        match   = hit0 | hit1;
        drain   = (count_q != 2'd0) && !MemRd_i;
        alloc   = is_st && !match && (count_q != 2'd2);
        busy_o  = is_st && (count_q == 2'd2) && !match;
        // Coalescing into the oldest entry lets a same-edge drain carry DataIn.
        data_c0 = (is_st && hit0) ? DataIn_i : data_q[0];
        data_c1 = (is_st && hit1) ? DataIn_i : data_q[1];

        DataOut_o = 16'h0000;
        if (is_ld) begin
            if (hit1)
                DataOut_o = data_q[1];
            else if (hit0)
                DataOut_o = data_q[0];
            else
                DataOut_o = mem_q[idx];
        end
    end

    always_comb begin
        addr_d[0] = addr_q[0];
        addr_d[1] = addr_q[1];
        data_d[0] = data_c0;
        data_d[1] = data_c1;
        cnt_tmp   = count_q;

        if (drain) begin
            addr_d[0] = addr_q[1];
            data_d[0] = data_c1;
            cnt_tmp   = count_q - 2'd1;
        end

        count_d = cnt_tmp;
        if (alloc) begin
            addr_d[cnt_tmp[0]] = idx;
            data_d[cnt_tmp[0]] = DataIn_i;
            count_d            = cnt_tmp + 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q   <= 2'd0;
            addr_q[0] <= '0;
            addr_q[1] <= '0;
            data_q[0] <= 16'h0000;
            data_q[1] <= 16'h0000;
        end else begin
            count_q   <= count_d;
            addr_q[0] <= addr_d[0];
            addr_q[1] <= addr_d[1];
            data_q[0] <= data_d[0];
            data_q[1] <= data_d[1];
        end
    end

    // Array keeps its contents across reset; only pending stores are dropped.
    always_ff @(posedge clk_i) begin
        if (!reset_i && drain)
            mem_q[addr_q[0]] <= data_c0;
    end

    assign wb_count_o = count_q;

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Bench for dmem_write_buffer: directed scenarios then random traffic,
// checked against a queue-based reference model of the buffer and array.
module tb_dmem_write_buffer;

    typedef struct {
        logic [7:0]  a;
        logic [15:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRd;
    logic        MemWr;
    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic [15:0] DataOut;
    logic        busy;
    logic [1:0]  wb_count;

    ent_t        q[$];
    logic [15:0] mem_m [256];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    dmem_write_buffer #(.ADDR_W(8)) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .MemRd_i   (MemRd),
        .MemWr_i   (MemWr),
        .Addr_i    (Addr),
        .DataIn_i  (DataIn),
        .DataOut_o (DataOut),
        .busy_o    (busy),
        .wb_count_o(wb_count)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic rd, input logic wr,
                        input logic [15:0] a, input logic [15:0] d);
        logic [7:0]  ai;
        int          hit;
        logic [15:0] e_dout;
        logic        e_busy;
        int          pre;
        reset  = rst;
        MemRd  = rd;
        MemWr  = wr;
        Addr   = a;
        DataIn = d;
        ai     = a[7:0];
        hit    = -1;
        for (int j = q.size() - 1; j >= 0; j--)
            if (hit < 0 && q[j].a == ai) hit = j;
        e_dout = 16'h0000;
        if (rd && !wr) e_dout = (hit >= 0) ? q[hit].d : mem_m[ai];
        e_busy = wr && q.size() == 2 && hit < 0;
        @(negedge clk);
        chk("dout", DataOut, e_dout);
        chk("busy", 16'(busy), 16'(e_busy));
        chk("count", 16'(wb_count), 16'(q.size()));
        pre = q.size();
        if (rst) begin
            q.delete();
        end else begin
            if (wr && hit >= 0) q[hit].d = d;
            if (q.size() > 0 && !rd) begin
                mem_m[q[0].a] = q[0].d;
                void'(q.pop_front());
            end
            if (wr && hit < 0 && pre < 2) q.push_back('{a: ai, d: d});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] a;
        logic        r;
        logic        w;
        reset = 1'b1; MemRd = 1'b0; MemWr = 1'b0; Addr = '0; DataIn = '0;
        @(posedge clk);
        #1;
        step(1, 0, 0, 16'h0, 16'h0);
        step(0, 0, 0, 16'h0, 16'h0);

        // Fill the whole array so every later load has a known value.
        for (int i = 0; i < 256; i++)
            step(0, 0, 1, 16'(i), 16'($urandom));
        step(0, 0, 0, 16'h0, 16'h0);
        step(0, 0, 0, 16'h0, 16'h0);

        step(0, 0, 1, 16'h0005, 16'h1234);
        step(0, 0, 0, 16'h0, 16'h0);
        step(0, 1, 0, 16'h0005, 16'h0);
        chk("load_05", DataOut, 16'h1234);

        step(0, 0, 1, 16'h0010, 16'hAAAA);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 16'h0010, 16'h0);
        step(0, 0, 0, 16'h0, 16'h0);
        step(0, 0, 0, 16'h0, 16'h0);

        step(0, 1, 1, 16'h0020, 16'h0001);
        step(0, 1, 0, 16'h0001, 16'h0);
        step(0, 1, 1, 16'h0021, 16'h0002);
        step(0, 1, 0, 16'h0001, 16'h0);
        step(0, 1, 1, 16'h0022, 16'h0003);
        step(0, 0, 0, 16'h0, 16'h0);
        step(0, 1, 1, 16'h0022, 16'h0003);
        step(0, 1, 0, 16'h0020, 16'h0);
        step(0, 1, 0, 16'h0021, 16'h0);
        step(0, 1, 0, 16'h0022, 16'h0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 16'h0, 16'h0);

        step(0, 1, 1, 16'h0030, 16'h0007);
        step(0, 1, 1, 16'h0031, 16'h0008);
        step(0, 1, 1, 16'h0030, 16'h0099);
        step(0, 1, 0, 16'h0030, 16'h0);
        chk("coalesce_30", DataOut, 16'h0099);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 16'h0, 16'h0);

        step(0, 1, 1, 16'h0040, 16'h5555);
        step(1, 1, 0, 16'h0, 16'h0);
        step(0, 1, 0, 16'h0040, 16'h0);

        step(0, 1, 1, 16'h0007, 16'hBEEF);
        step(0, 1, 0, 16'h0007, 16'h0);
        chk("rdwr_07", DataOut, 16'hBEEF);
        step(0, 0, 0, 16'h0, 16'h0);
        step(0, 0, 0, 16'h0, 16'h0);

        for (int i = 0; i < 3000; i++) begin
            a = 16'($urandom);
            if ($urandom_range(0, 3) != 0) a[7:0] = 8'($urandom_range(0, 7));
            r = 1'($urandom);
            w = 1'($urandom);
            step($urandom_range(0, 199) == 0, r, w, a, 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
